// File: rtl/alu_seq.sv
// alu_seq: multi-cycle WIDTH-bit ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arith/SLT ops, iterative one-bit-per-cycle SLL/SRA, and an
// optional shift-add multiplier compiled in with `define ALU_SEQ_MUL_EN.
// Without ALU_SEQ_MUL_EN, op 7 completes in one cycle as an illegal-op marker
// (Result=0, Zero=1, CarryOut=0, Overflow=1).
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [1:0] MUL   = 2'd2;
`endif
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] sh_q;
  logic             sra_q;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic             add_ovf;
  logic [WIDTH-1:0] imm_res;
  logic             imm_c;
  logic             imm_v;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sh_next;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [SHW:0] MUL_STEPS = (SHW+1)'(WIDTH);

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_next;

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
    acc_next = {mul_sum, acc_q[WIDTH-1:1]};
  end
`endif

  assign in_ready  = (state == IDLE) & ~reset;
  assign out_valid = (state == DONE);
  assign shamt     = B[SHW-1:0];

  // Single-cycle datapath on the live inputs; SLT reuses the subtractor and
  // corrects the sign with the overflow bit so it stays right on A-B overflow.
  always_comb begin
    is_sub  = (ALUOp == OP_SUB) || (ALUOp == OP_SLT);
    b_eff   = is_sub ? ~B : B;
    sum_ext = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    add_ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
    imm_res = '0;
    imm_c   = 1'b0;
    imm_v   = 1'b0;
    case (ALUOp)
      OP_AND: imm_res = A & B;
      OP_OR:  imm_res = A | B;
      OP_ADD, OP_SUB: begin
        imm_res = sum_ext[WIDTH-1:0];
        imm_c   = sum_ext[WIDTH];
        imm_v   = add_ovf;
      end
      OP_SLT: imm_res = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH-1] ^ add_ovf};
      default: ;
    endcase
  end

  // One-bit shift step; SRA replicates the sign bit.
  always_comb begin
    sh_next = sra_q ? {sh_q[WIDTH-1], sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], 1'b0};
  end

  // Control FSM plus registered result/flags. Multi-cycle ops finish on the
  // same edge as their last step so latency is shamt+1 / WIDTH+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sh_q     <= '0;
      sra_q    <= 1'b0;
      Result   <= '0;
      CarryOut <= 1'b0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            case (ALUOp)
              OP_SLL, OP_SRA: begin
                if (shamt == '0) begin
                  Result   <= A;
                  Zero     <= (A == '0);
                  CarryOut <= 1'b0;
                  Overflow <= 1'b0;
                  state    <= DONE;
                end else begin
                  sh_q  <= A;
                  sra_q <= (ALUOp == OP_SRA);
                  cnt   <= {1'b0, shamt};
                  state <= SHIFT;
                end
              end
              OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                acc_q   <= {{WIDTH{1'b0}}, B};
                mcand_q <= A;
                cnt     <= MUL_STEPS;
                state   <= MUL;
`else
                Result   <= '0;
                Zero     <= 1'b1;
                CarryOut <= 1'b0;
                Overflow <= 1'b1;
                state    <= DONE;
`endif
              end
              default: begin
                Result   <= imm_res;
                Zero     <= (imm_res == '0);
                CarryOut <= imm_c;
                Overflow <= imm_v;
                state    <= DONE;
              end
            endcase
          end
        end
        SHIFT: begin
          if (cnt == CNT_ONE) begin
            Result   <= sh_next;
            Zero     <= (sh_next == '0);
            CarryOut <= 1'b0;
            Overflow <= 1'b0;
            state    <= DONE;
          end else begin
            sh_q <= sh_next;
            cnt  <= cnt - CNT_ONE;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          if (cnt == CNT_ONE) begin
            Result   <= acc_next[WIDTH-1:0];
            Zero     <= (acc_next[WIDTH-1:0] == '0);
            CarryOut <= 1'b0;
            Overflow <= |acc_next[2*WIDTH-1:WIDTH];
            state    <= DONE;
          end else begin
            acc_q <= acc_next;
            cnt   <= cnt - CNT_ONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq. The driver pushes model results
// into a queue on each issued op; a monitor pops and compares when out_valid
// rises, checks latency, hold-stability under backpressure and in_ready reopening.
module tb_alu_seq;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
    int           lat;
    int           c0;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   alu_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic         overflow;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   force_stall = -1;
  exp_t sb[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .ALUOp(alu_op), .out_valid(out_valid), .out_ready(out_ready),
    .Result(result), .CarryOut(carry_out), .Zero(zero), .Overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model from the arithmetic definitions of each op.
  function automatic exp_t model(input int op, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t   e;
    longint ua, ub, sa, sbv, r, s;
    int     sh;
    ua  = longint'(av);
    ub  = longint'(bv);
    sa  = av[W-1] ? ua - (64'sd1 <<< W) : ua;
    sbv = bv[W-1] ? ub - (64'sd1 <<< W) : ub;
    sh  = int'(bv % W);
    e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.c0 = 0; r = 0;
    case (op)
      0: r = ua & ub;
      1: r = ua | ub;
      2: begin
        r = ua + ub; e.c = (r >= (64'sd1 <<< W));
        s = sa + sbv; e.v = (s >= (64'sd1 <<< (W-1))) || (s < -(64'sd1 <<< (W-1)));
      end
      3: begin
        r = ua - ub; e.c = (ua >= ub);
        s = sa - sbv; e.v = (s >= (64'sd1 <<< (W-1))) || (s < -(64'sd1 <<< (W-1)));
      end
      4: r = (sa < sbv) ? 1 : 0;
      5: begin r = ua << sh;  e.lat = (sh == 0) ? 1 : sh + 1; end
      6: begin r = sa >>> sh; e.lat = (sh == 0) ? 1 : sh + 1; end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        r = ua * ub; e.v = ((r >> W) != 0); e.lat = W + 1;
`else
        r = 0; e.v = 1'b1; e.lat = 1;
`endif
      end
    endcase
    e.res = r[W-1:0];
    e.z   = (e.res == '0);
    return e;
  endfunction

  // Waits (bounded) for in_ready, presents one op for exactly one edge, then scrambles inputs.
  task automatic send(input int op, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   budget = 0;
    @(negedge clk);
    while (!in_ready) begin
      if (budget++ > 200) begin
        chk("in_ready_timeout", 64'd0, 64'd1);
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b1; a = av; b = bv; alu_op = 3'(op);
    e = model(op, av, bv);
    e.c0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); alu_op = 3'($urandom);
  endtask

  // Monitor: compare first valid cycle against the scoreboard, then check hold and release.
  bit   busy = 1'b0;
  bit   prev_hs = 1'b0;
  int   stall = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (reset) begin
      busy = 1'b0; prev_hs = 1'b0; stall = 0; out_ready = 1'b0;
    end else begin
      if (prev_hs) begin
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_out_valid", 64'(out_valid), 64'd0);
      end
      prev_hs = 1'b0;
      if (out_valid) begin
        if (!busy) begin
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 64'd1, 64'd0);
            cur = '{res: result, c: carry_out, z: zero, v: overflow, lat: 0, c0: 0};
          end else begin
            cur = sb.pop_front();
            chk("result", 64'(result), 64'(cur.res));
            chk("carry_out", 64'(carry_out), 64'(cur.c));
            chk("zero", 64'(zero), 64'(cur.z));
            chk("overflow", 64'(overflow), 64'(cur.v));
            chk("latency", 64'(cyc - cur.c0), 64'(cur.lat));
          end
          busy  = 1'b1;
          stall = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 2));
        end else begin
          chk("hold_outputs", 64'({result, carry_out, zero, overflow}),
              64'({cur.res, cur.c, cur.z, cur.v}));
          chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = (stall == 0);
        if (stall > 0) stall--;
        if (out_ready) begin
          prev_hs = 1'b1;
          busy    = 1'b0;
        end
      end else begin
        out_ready = 1'(($urandom_range(0, 1)));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    logic [W-1:0] rb;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_op = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({result, carry_out, zero, overflow, out_valid}), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1 chk("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Directed boundary cases.
    send(2, 16'h7FFF, 16'h0001);
    send(3, 16'h0005, 16'h0005);
    send(4, 16'h8000, 16'h0001);
    send(4, 16'h7FFF, 16'h8000);
    send(6, 16'h8000, 16'h0004);
    send(5, 16'h0003, 16'h0010);
    send(5, 16'h0001, 16'h000F);
    send(7, 16'h0100, 16'h0100);
    send(7, 16'h00FF, 16'h0003);
    send(0, 16'hF0F0, 16'h0F0F);
    send(1, 16'hF000, 16'h000F);
    force_stall = 3;
    send(2, 16'hFFFF, 16'h0001);
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin @(negedge clk); budget++; end
    force_stall = -1;

    // Reset in the middle of a long op.
`ifdef ALU_SEQ_MUL_EN
    send(7, 16'h1234, 16'h0567);
`else
    send(5, 16'h0001, 16'h000F);
`endif
    repeat (6) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midop_reset_outputs", 64'({result, carry_out, zero, overflow, out_valid}), 64'd0);
    chk("midop_reset_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("midop_post_reset_in_ready", 64'(in_ready), 64'd1);
    send(2, 16'h0002, 16'h0003);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, W - 1)) : W'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(int'($urandom_range(0, 7)), W'($urandom), rb);
    end

    budget = 0;
    while ((sb.size() != 0 || out_valid) && budget < 200) begin @(negedge clk); budget++; end
    if (budget >= 200) chk("drain_timeout", 64'd0, 64'd1);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU; next generation of the team's 16-bit combinational ALU, extended to a WIDTH-bit datapath. It adds iterative shifters and an optional shift-add multiplier. It sits between the register-file read stage and write-back of the CPU datapath. Operands are accepted and results delivered over valid/ready handshakes, so variable-latency ops can stall the pipeline.

## Interface
- `WIDTH`, 16: datapath width; power of two, ≥ 4.
- `SHW`, `$clog2(WIDTH)`: shift-amount width (derived; do not override).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands/op presented.
- `in_ready`  out  1  block can accept; `(state==IDLE) & ~reset`.
- `A`  in  WIDTH  operand A.
- `B`  in  WIDTH  operand B; for shifts only `B[SHW-1:0]` is used.
- `ALUOp`  in  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 SLL, 6 SRA, 7 MUL.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer takes result.
- `Result`  out  WIDTH  registered result.
- `CarryOut`  out  1  registered carry flag.
- `Zero`  out  1  registered; `Result == 0`.
- `Overflow`  out  1  registered overflow flag.

## Operation
- States: IDLE, SHIFT, MUL, DONE.
- Transaction accepted when `in_valid & in_ready`. A, B and ALUOp are captured into internal registers at that edge; later input changes are ignored.
- IDLE → DONE for AND/OR/ADD/SUB/SLT, and for SLL/SRA with shamt 0. Result is computed and registered on the accepting edge.
- IDLE → SHIFT for SLL/SRA with shamt > 0:
  - one bit per cycle, countdown from shamt;
  - SRA replicates the MSB;
  - SHIFT → DONE when the count reaches 0.
- IDLE → MUL for op 7:
  - unsigned shift-add over exactly WIDTH cycles into a 2·WIDTH accumulator;
  - MUL → DONE after the last step.
- DONE: `out_valid=1`. Result and flags hold stable until `out_ready`; then DONE → IDLE.
- ADD: `A+B` mod 2^WIDTH. CarryOut = carry out of the MSB. Overflow = signed overflow.
- SUB: `A + ~B + 1`. CarryOut = 1 when there is no borrow (A ≥ B unsigned). Overflow = signed overflow.
- SLT: Result = 1 if `$signed(A) < $signed(B)`, else 0. Must be correct even when `A-B` overflows.
- MUL: Result = low WIDTH bits of the product. Overflow = 1 if the high WIDTH bits are nonzero.
- CarryOut = 0 for all ops except ADD/SUB. Overflow = 0 for all ops except ADD/SUB/MUL.
- Zero is valid for every op.

## Timing
- Reset (any state, including mid-SHIFT/MUL):
  - state → IDLE;
  - Result, CarryOut, Zero, Overflow, out_valid → 0;
  - in-flight op discarded;
  - `in_ready=0` while reset is high, and 1 from the first cycle after deassertion.
- Latency from accepting edge to first cycle with `out_valid=1`:
  - 1 cycle: logic/arith/SLT, and shifts with shamt 0;
  - shamt+1 cycles: SLL/SRA;
  - WIDTH+1 cycles: MUL.
- No overlap: in_ready stays low from acceptance until the cycle after the `out_valid & out_ready` edge. Minimum initiation interval is 2 cycles.
- Backpressure: out_valid stays high indefinitely while out_ready is low; outputs must not change.
- in_valid may stay high across transactions; a new acceptance occurs only in IDLE.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL state and WIDTH×WIDTH datapath are compiled in; op 7 behaves as specified.
- Not defined: no MUL state or accumulator. Op 7 goes IDLE → DONE in 1 cycle with Result=0, Zero=1, CarryOut=0, Overflow=1 (illegal-op marker).

## Test plan
- ADD, WIDTH=16, A=0x7FFF, B=0x0001 → Result 0x8000, CarryOut 0, Overflow 1, Zero 0; out_valid 1 cycle after accept.
- SUB, A=0x0005, B=0x0005 → Result 0, Zero 1, CarryOut 1, Overflow 0. SLT, A=0x8000, B=0x0001 → Result 1.
- SRA, A=0x8000, B=0x0004 → Result 0xF800, out_valid 5 cycles after accept. SLL, A=0x0003, B=0x0010 (shamt 0) → Result 0x0003 after 1 cycle.
- MUL, A=0x0100, B=0x0100, macro on → Result 0, Zero 1, Overflow 1 after 17 cycles. MUL, A=0x00FF, B=0x0003 → 0x02FD, Overflow 0. Macro off → Result 0, Overflow 1 after 1 cycle.
- Backpressure: hold out_ready=0 for 3 cycles after an ADD result → Result/flags/out_valid stable and in_ready=0; release → in_ready=1 the next cycle.
- Reset pulsed on cycle 8 of a MUL → all outputs 0 immediately, in_ready=1 after deassertion, and a following ADD 2+3 → 5.
